// File: rtl/fetch_align_if.sv
// Fetch-side beat handshake and decode-side instruction handshake for fetch_align.
// The master drives beats and consumes instructions; the slave is the aligner.
interface fetch_align_if #(
  parameter int FETCH_W = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [FETCH_W-1:0] in_data;
  logic [31:0]        in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic [31:0]        out_pc;
  logic               out_rvc;

  modport master (
    output in_valid, in_data, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_rvc
  );

  modport slave (
    input  in_valid, in_data, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_rvc
  );
endinterface

// File: rtl/fetch_align.sv
// Halfword realignment buffer: takes fetch beats, emits one 16- or 32-bit instruction
// per cycle, handling RVC mixes, beat-straddling instructions and halfword-offset targets.
module fetch_align #(
  parameter int FETCH_W = 64,
  parameter int DEPTH   = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  fetch_align_if.slave  bus
);
  localparam int HW = FETCH_W / 16;
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(HW);

  logic [15:0]   buf_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW:0]   count_q;
  logic [31:0]   pc_q;
  logic          pc_load_q;

  logic [OW-1:0] off;
  logic [PW:0]   push_n;
  logic [PW:0]   pop_m;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail;
  logic [15:0]   hw0;
  logic [15:0]   hw1;
  logic          is_rvc;
  logic          push;
  logic          pop;

  assign off     = bus.in_pc[OW:1];
  assign push_n  = (PW+1)'(HW) - (PW+1)'(off);
  assign head_p1 = head_q + PW'(1);
  assign tail    = head_q + count_q[PW-1:0];

  assign hw0    = buf_q[head_q];
  assign hw1    = buf_q[head_p1];
  assign is_rvc = (hw0[1:0] != 2'b11);
  assign pop_m  = is_rvc ? (PW+1)'(1) : (PW+1)'(2);

  // A 32-bit instruction whose upper halfword has not landed yet is held back.
  assign bus.out_valid = !flush && (count_q != '0) && (is_rvc || count_q >= (PW+1)'(2));
  assign bus.in_ready  = !flush && (count_q <= (PW+1)'(DEPTH - HW));
  assign bus.out_rvc   = is_rvc && (count_q != '0);
  assign bus.out_instr = is_rvc ? {16'h0000, hw0} : {hw1, hw0};
  assign bus.out_pc    = pc_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q    <= '0;
      count_q   <= '0;
      pc_q      <= '0;
      pc_load_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (flush) begin
      head_q    <= '0;
      count_q   <= '0;
      pc_load_q <= 1'b1;
    end else begin
      if (pop) begin
        head_q <= head_q + pop_m[PW-1:0];
        pc_q   <= pc_q + 32'({pop_m, 1'b0});
      end
      if (push) begin
        // Halfwords below the entry offset belong to the previous fetch group; drop them.
        for (int i = 0; i < HW; i++) begin
          if (i >= int'(off))
            buf_q[tail + PW'(i) - PW'(off)] <= bus.in_data[16*i +: 16];
        end
        if (pc_load_q) begin
          pc_q      <= bus.in_pc;
          pc_load_q <= 1'b0;
        end
      end
      count_q <= count_q + (push ? push_n : '0) - (pop ? pop_m : '0);
    end
  end
endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: expected instructions are queued as beats are
// driven and compared whenever the aligner hands an instruction to decode.
module tb_fetch_align;
  localparam int FETCH_W = 64;
  localparam int DEPTH   = 8;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];

  fetch_align_if #(.FETCH_W(FETCH_W)) bus ();

  fetch_align #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] instr, input logic [31:0] pc, input logic rvc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    e.rvc   = rvc;
    sb.push_back(e);
  endtask

  task automatic send_beat(input logic [31:0] pc, input logic [63:0] data);
    bit ok = 1'b0;
    int i  = 0;
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_data  = data;
    #1;
    while (!ok && i < 50) begin
      ok = bus.in_ready;
      tick();
      i++;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("beat_accept", 32'd0, 32'd1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #1;
    check("flush_ovalid", 32'(bus.out_valid), 32'd0);
    check("flush_iready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clock) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("extra_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_instr", bus.out_instr, e.instr);
        check("out_pc", bus.out_pc, e.pc);
        check("out_rvc", 32'(bus.out_rvc), 32'(e.rvc));
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_ovalid", 32'(bus.out_valid), 32'd0);
    check("rst_iready", 32'(bus.in_ready), 32'd1);
    check("rst_instr", bus.out_instr, 32'd0);
    check("rst_pc", bus.out_pc, 32'd0);
    check("rst_rvc", 32'(bus.out_rvc), 32'd0);

    // Two aligned 32-bit instructions; first visible the cycle after accept.
    bus.out_ready = 1'b1;
    expect_instr(32'h0000_0013, 32'h1000, 1'b0);
    expect_instr(32'h0000_0013, 32'h1004, 1'b0);
    send_beat(32'h1000, {32'h0000_0013, 32'h0000_0013});
    check("t1_latency", 32'(bus.out_valid), 32'd1);
    drain();
    check("t1_idle", 32'(bus.out_valid), 32'd0);

    // Four compressed halfwords.
    do_flush();
    expect_instr(32'h0000_4081, 32'h2000, 1'b1);
    expect_instr(32'h0000_0001, 32'h2002, 1'b1);
    expect_instr(32'h0000_0505, 32'h2004, 1'b1);
    expect_instr(32'h0000_4501, 32'h2006, 1'b1);
    send_beat(32'h2000, {16'h4501, 16'h0505, 16'h0001, 16'h4081});
    drain();

    // 32-bit instruction straddling two beats.
    do_flush();
    expect_instr(32'h0000_0001, 32'h4000, 1'b1);
    expect_instr(32'h0000_0001, 32'h4002, 1'b1);
    expect_instr(32'h0000_0001, 32'h4004, 1'b1);
    send_beat(32'h4000, {16'h0513, 16'h0001, 16'h0001, 16'h0001});
    repeat (5) tick();
    check("t3_straddle_hold", 32'(bus.out_valid), 32'd0);
    check("t3_straddle_q", 32'(sb.size()), 32'd0);
    expect_instr(32'h0000_0513, 32'h4006, 1'b0);
    expect_instr(32'h0000_0001, 32'h400A, 1'b1);
    expect_instr(32'h0000_0001, 32'h400C, 1'b1);
    expect_instr(32'h0000_0001, 32'h400E, 1'b1);
    send_beat(32'h4008, {16'h0001, 16'h0001, 16'h0001, 16'h0000});
    check("t3_after_beat2", 32'(bus.out_valid), 32'd1);
    drain();

    // Redirect to a halfword offset: lower halfwords dropped.
    do_flush();
    expect_instr(32'h0000_0002, 32'h3006, 1'b1);
    send_beat(32'h3006, {16'h0002, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    drain();
    check("t4_idle", 32'(bus.out_valid), 32'd0);

    // Fill to capacity with decode stalled, then release and wrap the head.
    do_flush();
    bus.out_ready = 1'b0;
    expect_instr(32'h0000_0093, 32'h5000, 1'b0);
    expect_instr(32'h0000_0113, 32'h5004, 1'b0);
    expect_instr(32'h0000_0213, 32'h5008, 1'b0);
    expect_instr(32'h0000_0193, 32'h500C, 1'b0);
    send_beat(32'h5000, {16'h0000, 16'h0113, 16'h0000, 16'h0093});
    check("t5_ready_half", 32'(bus.in_ready), 32'd1);
    send_beat(32'h9999_0000, {16'h0000, 16'h0193, 16'h0000, 16'h0213});
    check("t5_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    check("t5_count6", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    check("t5_count4", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    expect_instr(32'h0000_0293, 32'h5010, 1'b0);
    expect_instr(32'h0000_0001, 32'h5014, 1'b1);
    expect_instr(32'h0000_0001, 32'h5016, 1'b1);
    send_beat(32'h0, {16'h0001, 16'h0001, 16'h0000, 16'h0293});
    drain();

    // Flush colliding with push and pop.
    do_flush();
    bus.out_ready = 1'b0;
    send_beat(32'h6000, {16'h0001, 16'h0001, 16'h0001, 16'h0001});
    check("t6_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h6100;
    bus.in_data   = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    bus.out_ready = 1'b1;
    do_flush();
    bus.in_valid = 1'b0;
    #1;
    check("t6_empty", 32'(bus.out_valid), 32'd0);
    check("t6_ready", 32'(bus.in_ready), 32'd1);

    // Reset while a straddling instruction is half-buffered.
    expect_instr(32'h0000_0001, 32'h7000, 1'b1);
    expect_instr(32'h0000_0001, 32'h7002, 1'b1);
    expect_instr(32'h0000_0001, 32'h7004, 1'b1);
    send_beat(32'h7000, {16'h0513, 16'h0001, 16'h0001, 16'h0001});
    drain();
    check("t6_straddle_hold", 32'(bus.out_valid), 32'd0);
    check("t6_pre_rst_pc", bus.out_pc, 32'h7006);
    reset = 1'b1;
    tick();
    check("t6_rst_ovalid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_pc", bus.out_pc, 32'd0);
    reset = 1'b0;
    tick();
    expect_instr(32'h0000_0002, 32'h8000, 1'b1);
    expect_instr(32'h0000_0001, 32'h8002, 1'b1);
    expect_instr(32'h0000_0001, 32'h8004, 1'b1);
    expect_instr(32'h0000_0001, 32'h8006, 1'b1);
    send_beat(32'h8000, {16'h0001, 16'h0001, 16'h0001, 16'h0002});
    drain();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
